// File: rtl/gate_vector_sequencer_if.sv
// ---------------------------------------------------------------------------
// gate_vector_sequencer_if
//
// Purpose:
//   Bundles the run-control and gate-model signals of the gate vector
//   sequencer into one interface. The sequencer connects through the slave
//   modport. The harness side uses the master modport: it requests runs,
//   reads back status and signature, and hosts the gate model that turns
//   gate_in into gate_out.
//
// Signals:
//   start      run request, sampled by the sequencer only while idle
//   num_vec    number of vectors in the run (0 allowed)
//   gate_in    vector driven onto the gate model inputs (N1 = bit 0)
//   gate_out   gate model response sampled back by the sequencer
//   busy       high while a run is in progress
//   done       one-cycle pulse at the end of a run
//   vec_idx    index of the vector currently applied
//   signature  16-bit MISR result, stable from done until the next start
//
// Parameters:
//   IN_W   width of gate_in
//   OUT_W  width of gate_out (at most 16)
// ---------------------------------------------------------------------------
interface gate_vector_sequencer_if #(
   parameter int IN_W  = 21,
   parameter int OUT_W = 10
);

   logic             start;
   logic [21:0]      num_vec;
   logic [IN_W-1:0]  gate_in;
   logic [OUT_W-1:0] gate_out;
   logic             busy;
   logic             done;
   logic [21:0]      vec_idx;
   logic [15:0]      signature;

   // Harness side: issues runs, hosts the gate model, observes results.
   modport master (
      output start,
      output num_vec,
      output gate_out,
      input  gate_in,
      input  busy,
      input  done,
      input  vec_idx,
      input  signature
   );

   // Sequencer side.
   modport slave (
      input  start,
      input  num_vec,
      input  gate_out,
      output gate_in,
      output busy,
      output done,
      output vec_idx,
      output signature
   );

endinterface

// File: rtl/gate_vector_sequencer.sv
// ---------------------------------------------------------------------------
// gate_vector_sequencer
//
// Purpose:
//   Test harness stage for the combinational gate models of the simulator
//   gate library. For each run it applies num_vec input vectors to the gate
//   model, waits SETTLE cycles for the model to settle, and samples the
//   response. Every sample is folded into a 16-bit MISR signature, so one
//   run can be compared against a golden signature.
//
// Ports:
//   clk    single system clock, rising edge
//   rst_n  synchronous, active-low reset
//   bus    gate_vector_sequencer_if.slave
//            start, num_vec, gate_out  in
//            gate_in, busy, done, vec_idx, signature  out
//
// Parameters:
//   IN_W    width of the vector driven to the gate model (default 21)
//   OUT_W   width of the sampled response, at most 16 (default 10)
//   SETTLE  cycles between applying a vector and capturing it, >= 1
//
// Configuration macro:
//   GATE_VECTOR_LFSR_EN
//     Undefined (default): vectors come from a binary counter that starts
//       at 0 and wraps modulo 2^IN_W.
//     Defined: vectors come from a 21-bit Fibonacci LFSR (x^21 + x^19 + 1)
//       seeded with 21'h000001. IN_W must be 21 in this mode.
//   The FSM, timing and MISR are identical in both builds.
//
// Timing:
//   Each vector costs SETTLE+2 cycles: APPLY (1), SETTLE (SETTLE), and
//   CAPTURE (1). done is high in the cycle after edge k0 + N*(SETTLE+2),
//   where k0 is the edge that accepted start.
// ---------------------------------------------------------------------------
module gate_vector_sequencer #(
   parameter int IN_W   = 21,
   parameter int OUT_W  = 10,
   parameter int SETTLE = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   gate_vector_sequencer_if.slave  bus
);

   // The settle counter only needs to hold SETTLE-1 down to 0. A 1-bit
   // counter is kept when SETTLE is 1, so the vector is never zero-width.
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] settle_cnt;
   logic [21:0]      num_lat;
   logic [IN_W-1:0]  vec;
   logic [IN_W-1:0]  gate_in_r;
   logic             busy_r;
   logic             done_r;
   logic [21:0]      vec_idx_r;
   logic [15:0]      sig_r;

   // The vector generator is chosen at build time. Both options expose the
   // same two things: the first vector of a run (the seed) and a next-vector
   // function. As a result, the FSM below does not know which generator is
   // present.
`ifdef GATE_VECTOR_LFSR_EN
   localparam logic [IN_W-1:0] VEC_SEED = IN_W'(1);

   // Fibonacci LFSR with taps at bits 20 and 18 (x^21 + x^19 + 1). It never
   // reaches all-zero from a nonzero seed, and it returns to the seed after
   // 2^21-1 steps.
   function automatic logic [IN_W-1:0] next_vec(input logic [IN_W-1:0] v);
      return {v[19:0], v[20] ^ v[18]};
   endfunction
`else
   localparam logic [IN_W-1:0] VEC_SEED = '0;

   // Plain binary counter. Overflow wraps back to 0, so a run longer than
   // 2^IN_W vectors simply repeats the sequence.
   function automatic logic [IN_W-1:0] next_vec(input logic [IN_W-1:0] v);
      return v + IN_W'(1);
   endfunction
`endif

   // One MISR step: shift left with feedback from bits 15, 13, 12 and 10,
   // then XOR in the zero-extended response.
   function automatic logic [15:0] misr_next(input logic [15:0]      s,
                                             input logic [OUT_W-1:0] r);
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      return {s[14:0], fb} ^ 16'(r);
   endfunction

   // Main sequencer FSM. All outputs are registered here, so busy and done
   // change on the same edges as the state that implies them.
   //
   // A run walks APPLY -> SETTLE -> CAPTURE once per vector. CAPTURE either
   // loops back to APPLY for the next vector or finishes the run in DONE.
   //
   // The length check compares vec_idx with the latched count minus one,
   // never with the live num_vec input. This is why changing num_vec
   // mid-run has no effect.
   //
   // done defaults low every cycle. It is raised only on the edge that
   // enters DONE, which makes it a single-cycle pulse by construction.
   //
   // gate_in is loaded only in APPLY. It therefore keeps the last vector
   // after a run, and stays untouched by a zero-length run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         num_lat    <= '0;
         vec        <= '0;
         gate_in_r  <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         vec_idx_r  <= '0;
         sig_r      <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  sig_r <= '0;
                  if (bus.num_vec != 22'd0) begin
                     num_lat   <= bus.num_vec;
                     vec       <= VEC_SEED;
                     vec_idx_r <= '0;
                     busy_r    <= 1'b1;
                     state     <= ST_APPLY;
                  end else begin
                     done_r <= 1'b1;
                     state  <= ST_DONE;
                  end
               end
            end

            ST_APPLY: begin
               gate_in_r  <= vec;
               settle_cnt <= SETTLE_LOAD;
               state      <= ST_SETTLE;
            end

            ST_SETTLE: begin
               if (settle_cnt == '0) begin
                  state <= ST_CAPTURE;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end

            ST_CAPTURE: begin
               sig_r <= misr_next(sig_r, bus.gate_out);
               if (vec_idx_r == num_lat - 22'd1) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  vec_idx_r <= vec_idx_r + 22'd1;
                  vec       <= next_vec(vec);
                  state     <= ST_APPLY;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Registered state is driven straight onto the interface.
   assign bus.gate_in   = gate_in_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.vec_idx   = vec_idx_r;
   assign bus.signature = sig_r;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gate_vector_sequencer
//
// Purpose:
//   Self-checking bench for gate_vector_sequencer.
//
//   Stimulus process:
//     Issues runs, both directed and random. For each run it computes the
//     expected outcome from a high-level reference model and pushes it to a
//     scoreboard queue.
//
//   Monitor process:
//     Pops an entry and compares it whenever the DUT pulses done.
//
//   Reference model:
//     Enumerates the run's vectors directly (i mod 2^IN_W, or the LFSR rule
//     when GATE_VECTOR_LFSR_EN is defined). It pushes each vector through
//     the bench's gate model and folds the responses with the MISR rule.
// ---------------------------------------------------------------------------
module tb_gate_vector_sequencer;

   localparam int IN_W   = 21;
   localparam int OUT_W  = 10;
   localparam int SETTLE = 2;
   localparam int PER    = SETTLE + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   resp_mode = 1;

   always #5 clk = ~clk;

   // Free-running cycle count. It is read only on falling edges, when it is
   // stable.
   always @(posedge clk) cyc <= cyc + 1;

   gate_vector_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   gate_vector_sequencer #(
      .IN_W(IN_W),
      .OUT_W(OUT_W),
      .SETTLE(SETTLE)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Gate model used as the DUT's load.
   //   mode 0: a multiplicative hash of the vector
   //   mode 1: constant 1
   //   mode 2: constant 0
   function automatic logic [OUT_W-1:0] gate_fn(input logic [IN_W-1:0] v,
                                                input int mode);
      logic [31:0] h;
      case (mode)
         1: return OUT_W'(1);
         2: return '0;
         default: begin
            h = {11'd0, v} * 32'h9E3779B1;
            return h[26:17];
         end
      endcase
   endfunction

   assign bus.gate_out = gate_fn(bus.gate_in, resp_mode);

   typedef struct {
      logic [15:0]     sig;
      int              n;
      int              done_cyc;
      logic [IN_W-1:0] last_vec;
      logic [21:0]     last_idx;
   } exp_t;

   exp_t sb[$];

   // What gate_in and vec_idx should hold after the most recent completed
   // run. Used as the expectation for zero-length runs.
   logic [IN_W-1:0] model_gate_in = '0;
   logic [21:0]     model_idx     = '0;

   // Reference model for one run of n vectors, started at a falling edge
   // where the cycle count reads c.
   function automatic exp_t predict(input int n, input int mode, input int c);
      exp_t            e;
      logic [15:0]     s    = '0;
      logic [IN_W-1:0] v    = model_gate_in;
      logic [IN_W-1:0] lfsr = IN_W'(1);
      for (int i = 0; i < n; i++) begin
`ifdef GATE_VECTOR_LFSR_EN
         v    = lfsr;
         lfsr = {lfsr[19:0], lfsr[20] ^ lfsr[18]};
`else
         v = IN_W'(i);
`endif
         s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ 16'(gate_fn(v, mode));
      end
      e.sig      = s;
      e.n        = n;
      e.done_cyc = c + 1 + n * PER;
      e.last_vec = v;
      e.last_idx = (n > 0) ? 22'(n - 1) : model_idx;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Issue one run and leave the bench in the IDLE cycle that follows DONE.
   // When noisy is set:
   //   - start and num_vec are toggled randomly while the run is busy;
   //   - start is held high across the edge that leaves DONE.
   // The DUT must ignore all of this.
   task automatic applyStimulus(input int n, input int mode, input bit noisy);
      exp_t e;
      int   k;
      int   budget;
      resp_mode = mode;
      e = predict(n, mode, cyc);
      sb.push_back(e);
      model_gate_in = e.last_vec;
      model_idx     = e.last_idx;
      bus.num_vec   = 22'(n);
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      budget = n * PER + 10;
      k = 0;
      while (!bus.done && k < budget) begin
         if (noisy) begin
            bus.start   = 1'($urandom_range(0, 1));
            bus.num_vec = 22'($urandom_range(0, 50));
         end
         @(negedge clk);
         k++;
      end
      if (!bus.done) begin
         total++;
         bad++;
         $display("[TB] FAIL run_timeout: no done after %0d cycles for num_vec=%0d", k, n);
      end
      bus.start = noisy;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Start a 5-vector run, then reset during the second vector's settle.
   // Every output must clear on the reset edge.
   task automatic resetMidRun();
      resp_mode   = 0;
      bus.num_vec = 22'd5;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_busy",      32'(bus.busy),      32'd0);
      checkOutput("rst_mid_done",      32'(bus.done),      32'd0);
      checkOutput("rst_mid_gate_in",   32'(bus.gate_in),   32'd0);
      checkOutput("rst_mid_signature", 32'(bus.signature), 32'd0);
      checkOutput("rst_mid_vec_idx",   32'(bus.vec_idx),   32'd0);
      model_gate_in = '0;
      model_idx     = '0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Monitor. On every done pulse it pops an expectation and checks:
   //   - signature, vec_idx and gate_in;
   //   - the exact cycle of the pulse;
   //   - the number of busy cycles in the run;
   //   - that done lasts a single cycle.
   // A run cut short by reset shows busy falling without done, so its busy
   // tally is discarded.
   initial begin : monitor
      exp_t e;
      int   busy_cnt  = 0;
      bit   prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (prev_busy && !bus.busy && !bus.done) busy_cnt = 0;
         prev_busy = bus.busy;
         if (bus.done) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("signature",   32'(bus.signature), 32'(e.sig));
               checkOutput("vec_idx",     32'(bus.vec_idx),   32'(e.last_idx));
               checkOutput("gate_in_hold", 32'(bus.gate_in),  32'(e.last_vec));
               checkOutput("done_cycle",  32'(cyc),           32'(e.done_cyc));
               checkOutput("busy_cycles", 32'(busy_cnt),      32'(e.n * PER));
               checkOutput("busy_at_done", 32'(bus.busy),     32'd0);
            end
            busy_cnt = 0;
            @(negedge clk);
            checkOutput("done_width", 32'(bus.done), 32'd0);
            prev_busy = bus.busy;
            if (bus.busy) busy_cnt++;
         end
      end
   end

   // Main sequence:
   //   1. reset-state checks;
   //   2. directed boundary runs;
   //   3. mid-run reset;
   //   4. random runs;
   //   5. a 4-vector run and a long signature run.
   initial begin : stim
      int waited;
      bus.start   = 1'b0;
      bus.num_vec = '0;
      rst_n       = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy",      32'(bus.busy),      32'd0);
      checkOutput("reset_done",      32'(bus.done),      32'd0);
      checkOutput("reset_gate_in",   32'(bus.gate_in),   32'd0);
      checkOutput("reset_vec_idx",   32'(bus.vec_idx),   32'd0);
      checkOutput("reset_signature", 32'(bus.signature), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(1, 1, 1'b0);
      applyStimulus(2, 1, 1'b0);
      applyStimulus(0, 0, 1'b0);
      applyStimulus(100, 2, 1'b0);
      applyStimulus(3, 0, 1'b1);
      resetMidRun();
      applyStimulus(5, 0, 1'b0);
      applyStimulus(0, 0, 1'b1);
      repeat (10) begin
         applyStimulus(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)));
      end
      applyStimulus(4, 0, 1'b0);
      applyStimulus(4096, 0, 1'b0);

      waited = 0;
      while (sb.size() != 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
